pipeline_run_ctrl: RTL
======================

PIPELINE_RUN_CTRL -- requirements
Module: pipeline_run_ctrl

Interface
REQ-001 The parameters SHALL be, one per line:
- IMEM_AW, default 9, instruction-memory address width.
- RST_HOLD, default 2, cycles pipe_rst is held before a run.
- CYC_W, default 16, run-cycle counter width.
REQ-002 The ports SHALL be, one per line:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_load  in  1  one-cycle pulse; start an I-mem load.
- load_base  in  IMEM_AW  first I-mem address; sampled with cmd_load.
- load_count  in  IMEM_AW+1  number of words; sampled with cmd_load.
- cmd_run  in  1  one-cycle pulse; start a program run.
- run_cycles  in  CYC_W  clocks the pipeline runs; sampled with cmd_run.
- cmd_abort  in  1  return to IDLE from any state.
- wr_valid  in  1  host instruction word valid.
- wr_data  in  32  host instruction word.
- wr_ready  out  1  controller accepts word.
- Instr_IN  out  32  I-mem write data to pipeline.
- Instr_W_en  out  1  I-mem write enable to pipeline.
- I_W_Addr  out  IMEM_AW  I-mem write address to pipeline.
- pipe_rst  out  1  pipeline reset.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle completion pulse.
- cyc_count  out  CYC_W  clocks elapsed in the current or last run.
REQ-003 The reset SHALL be asynchronous and active-high on port rst; the clock SHALL be the single port clk.

Function
REQ-004 The FSM SHALL have states IDLE, LOAD, PRST, RUN and DONE.
REQ-005 In IDLE, cmd_load SHALL capture load_base and load_count and go to LOAD; if load_count==0 it SHALL go to DONE instead.
REQ-006 In IDLE, cmd_run SHALL capture run_cycles and go to PRST; if both commands are high together, cmd_load SHALL win and cmd_run SHALL be dropped.
REQ-007 cmd_load and cmd_run outside IDLE SHALL be ignored.
REQ-008 wr_ready SHALL be 1 only in LOAD; a word is accepted on any cycle with wr_valid && wr_ready.
REQ-009 Each accepted word SHALL drive Instr_IN=wr_data, Instr_W_en=1 and I_W_Addr=load_base+index, all registered, so each write is visible one cycle after acceptance.
REQ-010 The index SHALL start at 0 and the address SHALL wrap modulo 2^IMEM_AW.
REQ-011 Instr_W_en SHALL be 0 on every cycle with no acceptance; wr_valid gaps SHALL stall LOAD without timeout.
REQ-012 On acceptance of word load_count-1, LOAD SHALL go to DONE.
REQ-013 PRST SHALL hold pipe_rst=1 for exactly RST_HOLD cycles and then go to RUN; if captured run_cycles==0 it SHALL go to DONE with no RUN cycle.
REQ-014 In RUN, pipe_rst SHALL be 0 and cyc_count SHALL increment every clock from 0.
REQ-015 RUN SHALL exit to DONE on the cycle cyc_count reaches run_cycles-1, so pipe_rst is low for exactly run_cycles clocks.
REQ-016 pipe_rst SHALL be 1 in every state except RUN.
REQ-017 DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-018 cyc_count SHALL clear on entry to PRST and otherwise hold its value outside RUN.
REQ-019 cmd_abort SHALL force IDLE on the next edge from any state, take priority over all commands, suppress done, and deassert Instr_W_en.
REQ-020 busy SHALL equal (state != IDLE).

Reset
REQ-021 While rst=1, and on its asynchronous assertion, the outputs SHALL be: state=IDLE, pipe_rst=1, Instr_W_en=0, Instr_IN=0, I_W_Addr=0, wr_ready=0, done=0, busy=0, cyc_count=0.
REQ-022 rst asserted mid-LOAD or mid-RUN SHALL abandon the operation with no further I-mem write.

Structure
REQ-023 The FSM state encoding and the RST_HOLD and CYC_W defaults SHALL live in a shared package, pipe_ctrl_pkg.
REQ-024 The design SHALL be a single module plus one natural sub-module, imem_loader, which implements the LOAD handshake and the address counter.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Load 3 words at base 0x1FE -> writes at 0x1FE, 0x1FF, 0x000; done one cycle after the third write; pipe_rst stays 1 throughout.
- Load of 4 words with wr_valid low on alternate cycles -> exactly 4 Instr_W_en pulses, in order, with no duplicate writes.
- Run with run_cycles=10 -> pipe_rst high 2 cycles, then low exactly 10 cycles; done pulse; cyc_count=9.
- cmd_load and cmd_run together in IDLE -> LOAD entered; the run never occurs.
- cmd_abort at RUN cycle 5 -> pipe_rst=1 on the next edge, no done pulse, busy=0.
- Async rst mid-LOAD after 2 of 5 words -> outputs at reset values immediately; no third write.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared definitions for the pipeline run controller: FSM
//                state encoding and the default widths / reset-hold length
//                used by pipeline_run_ctrl and imem_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam int IMEM_AW_DEFAULT  = 9;
    localparam int RST_HOLD_DEFAULT = 2;
    localparam int CYC_W_DEFAULT    = 16;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PRST = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Host-to-I-mem load path. Captures the load window, accepts
//                host words on wr_valid && wr_ready and turns each accepted
//                word into a registered single-cycle I-mem write at
//                load_base + index (address wraps at 2^IMEM_AW).
//  Ports       : clk, rst         - clock, async active-high reset
//                start            - capture load_base / load_count, index=0
//                load_base/count  - load window
//                wr_ready         - controller is in LOAD (from the FSM)
//                wr_valid/wr_data - host word
//                abort            - blocks acceptance this cycle
//                last_accept      - the final word of the window is accepted
//                Instr_IN, Instr_W_en, I_W_Addr - registered I-mem write port
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import pipe_ctrl_pkg::*;
#(
    parameter int IMEM_AW = IMEM_AW_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IMEM_AW-1:0] load_base,
    input  logic [IMEM_AW:0]   load_count,
    input  logic               wr_ready,
    input  logic               wr_valid,
    input  logic [31:0]        wr_data,
    input  logic               abort,
    output logic               last_accept,
    output logic [31:0]        Instr_IN,
    output logic               Instr_W_en,
    output logic [IMEM_AW-1:0] I_W_Addr
);

    logic [IMEM_AW-1:0] r_base;
    logic [IMEM_AW:0]   r_count;
    logic [IMEM_AW:0]   r_idx;
    logic               w_accept;

    // An abort in the same cycle wins over the handshake so no write escapes.
    assign w_accept    = wr_valid && wr_ready && !abort;
    assign last_accept = w_accept && (r_idx == (r_count - (IMEM_AW+1)'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base     <= '0;
            r_count    <= '0;
            r_idx      <= '0;
            Instr_IN   <= '0;
            Instr_W_en <= 1'b0;
            I_W_Addr   <= '0;
        end else begin
            // Write enable is a pure one-cycle echo of acceptance.
            Instr_W_en <= w_accept;
            if (start) begin
                r_base  <= load_base;
                r_count <= load_count;
                r_idx   <= '0;
            end else if (w_accept) begin
                Instr_IN <= wr_data;
                // Truncating sum gives the modulo-2^IMEM_AW wrap.
                I_W_Addr <= r_base + r_idx[IMEM_AW-1:0];
                r_idx    <= r_idx + (IMEM_AW+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_run_ctrl
//  Description : Controller that loads a program into the pipeline's I-mem
//                from a host stream and then runs the pipeline for a fixed
//                number of clocks, holding pipe_rst outside the run window.
//  Ports       : clk, rst            - clock, async active-high reset
//                cmd_load, load_base, load_count - start an I-mem load
//                cmd_run, run_cycles - start a run of run_cycles clocks
//                cmd_abort           - return to IDLE from any state
//                wr_valid/wr_data/wr_ready - host instruction stream
//                Instr_IN, Instr_W_en, I_W_Addr - I-mem write port
//                pipe_rst            - pipeline reset (low only in RUN)
//                busy, done          - status, done is a one-cycle pulse
//                cyc_count           - clocks elapsed in current/last run
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_run_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int IMEM_AW  = IMEM_AW_DEFAULT,
    parameter int RST_HOLD = RST_HOLD_DEFAULT,   // must be >= 1
    parameter int CYC_W    = CYC_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_load,
    input  logic [IMEM_AW-1:0] load_base,
    input  logic [IMEM_AW:0]   load_count,
    input  logic               cmd_run,
    input  logic [CYC_W-1:0]   run_cycles,
    input  logic               cmd_abort,
    input  logic               wr_valid,
    input  logic [31:0]        wr_data,
    output logic               wr_ready,
    output logic [31:0]        Instr_IN,
    output logic               Instr_W_en,
    output logic [IMEM_AW-1:0] I_W_Addr,
    output logic               pipe_rst,
    output logic               busy,
    output logic               done,
    output logic [CYC_W-1:0]   cyc_count
);

    localparam int                HOLD_W      = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    ctrl_state_t        r_state;
    logic [CYC_W-1:0]   r_run_cycles;
    logic [HOLD_W-1:0]  r_hold;
    logic               w_load_start;
    logic               w_last_accept;

    // Loader captures its window on every accepted cmd_load, including the
    // zero-length case (harmless: no word can be accepted outside LOAD).
    assign w_load_start = (r_state == ST_IDLE) && cmd_load && !cmd_abort;

    imem_loader #(
        .IMEM_AW (IMEM_AW)
    ) u_loader (
        .clk         (clk),
        .rst         (rst),
        .start       (w_load_start),
        .load_base   (load_base),
        .load_count  (load_count),
        .wr_ready    (wr_ready),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .abort       (cmd_abort),
        .last_accept (w_last_accept),
        .Instr_IN    (Instr_IN),
        .Instr_W_en  (Instr_W_en),
        .I_W_Addr    (I_W_Addr)
    );

    // All status outputs are registered and updated together with the state,
    // so each output always reflects the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_run_cycles <= '0;
            r_hold       <= '0;
            pipe_rst     <= 1'b1;
            wr_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cyc_count    <= '0;
        end else if (cmd_abort) begin
            // cyc_count is left alone so the aborted run length stays visible.
            r_state  <= ST_IDLE;
            pipe_rst <= 1'b1;
            wr_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_load) begin
                        busy <= 1'b1;
                        if (load_count == '0) begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state  <= ST_LOAD;
                            wr_ready <= 1'b1;
                        end
                    end else if (cmd_run) begin
                        r_state      <= ST_PRST;
                        busy         <= 1'b1;
                        r_run_cycles <= run_cycles;
                        r_hold       <= '0;
                        cyc_count    <= '0;
                    end
                end

                ST_LOAD: begin
                    if (w_last_accept) begin
                        r_state  <= ST_DONE;
                        wr_ready <= 1'b0;
                        done     <= 1'b1;
                    end
                end

                ST_PRST: begin
                    // The reset hold is always served in full; a zero-length
                    // run then completes without ever releasing pipe_rst.
                    if (r_hold == c_HOLD_LAST) begin
                        if (r_run_cycles == '0) begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state  <= ST_RUN;
                            pipe_rst <= 1'b0;
                        end
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end

                ST_RUN: begin
                    // cyc_count shows 0..run_cycles-1 across the RUN cycles
                    // and freezes on the last one.
                    if (cyc_count == (r_run_cycles - CYC_W'(1))) begin
                        r_state  <= ST_DONE;
                        pipe_rst <= 1'b1;
                        done     <= 1'b1;
                    end else begin
                        cyc_count <= cyc_count + CYC_W'(1);
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end

                default: begin
                    r_state  <= ST_IDLE;
                    pipe_rst <= 1'b1;
                    wr_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
